// File: rtl/adc_pkg.sv
// Shared defaults, FSM state encoding and timing helper for the ADC SPI reader.
package adc_pkg;

    localparam int unsigned ADC_DATA_BITS  = 12;
    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_CLK_DIV    = 4;
    localparam int unsigned ADC_PERIOD     = 1000;
    localparam int unsigned ADC_DONE_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } adc_state_t;

    // Shortest trigger period that never lands while a frame is still busy.
    function automatic int unsigned adc_min_period(
        input int unsigned clk_div,
        input int unsigned frame_bits,
        input int unsigned done_width
    );
        return clk_div * (2 + 2 * frame_bits) + done_width + 1;
    endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running conversion period counter; pulses trigger once per PERIOD clocks.
module period_timer
    import adc_pkg::*;
#(
    parameter int unsigned PERIOD = ADC_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic trigger
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Count 0..PERIOD-1 while enabled, hold at 0 otherwise; trigger on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            trigger <= 1'b0;
        end else if (!enable) begin
            count   <= '0;
            trigger <= 1'b0;
        end else if (count == LAST) begin
            count   <= '0;
            trigger <= 1'b1;
        end else begin
            count   <= count + CNT_W'(1);
            trigger <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master: one periodic ADC conversion, MSB-first capture, strobed result.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int unsigned DATA_BITS  = ADC_DATA_BITS,
    parameter int unsigned FRAME_BITS = ADC_FRAME_BITS,
    parameter int unsigned CLK_DIV    = ADC_CLK_DIV,
    parameter int unsigned PERIOD     = ADC_PERIOD,
    parameter int unsigned DONE_WIDTH = ADC_DONE_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 cs_n,
    output logic [DATA_BITS-1:0] data,
    output logic                 spiReceived,
    output logic                 busy,
    output logic                 overrun
);

    if (CLK_DIV < 2 || DONE_WIDTH < 2 || PERIOD < 2 ||
        FRAME_BITS < 2 || DATA_BITS > FRAME_BITS) begin : g_bad_config
        $error("adc_spi_reader: illegal parameter combination");
    end

    localparam int unsigned CNT_MAX = (CLK_DIV > DONE_WIDTH) ? CLK_DIV : DONE_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_WIDTH - 1);
    localparam logic [BIT_W-1:0] BITS_ALL  = BIT_W'(FRAME_BITS);

    logic                  trigger;
    adc_state_t            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [BIT_W-1:0]      bit_cnt, bit_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sclk_d, cs_n_d, rcv_d, busy_d, overrun_d;
    logic [DATA_BITS-1:0]  data_d;

    period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .trigger (trigger)
    );

    // State, datapath and all outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            sclk        <= 1'b0;
            cs_n        <= 1'b1;
            data        <= '0;
            spiReceived <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            bit_cnt     <= bit_d;
            shift_q     <= shift_d;
            sclk        <= sclk_d;
            cs_n        <= cs_n_d;
            data        <= data_d;
            spiReceived <= rcv_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
        end
    end

    // Frame sequencing: SETUP, FRAME_BITS SCLK periods, HOLD, then the DONE strobe.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_d     = bit_cnt;
        shift_d   = shift_q;
        sclk_d    = sclk;
        cs_n_d    = cs_n;
        data_d    = data;
        rcv_d     = spiReceived;
        busy_d    = busy;
        overrun_d = overrun | (trigger & (state != ST_IDLE));

        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == DIV_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk) begin
                        // Rising edge: ADC changed miso after the previous fall, so it is settled.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[FRAME_BITS-2:0], miso};
                        bit_d   = bit_cnt + BIT_W'(1);
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt == BITS_ALL) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == DIV_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    data_d  = shift_q[DATA_BITS-1:0];
                    rcv_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == DONE_LAST) begin
                    cnt_d   = '0;
                    rcv_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench: ADC serial model, switcher edge detector, timing/data reference.
module tb_adc_spi_reader;

    localparam int PER   = 1000;
    localparam int PER_S = 100;
    localparam int CD    = 4;
    localparam int FB    = 16;
    localparam int DW    = 4;
    // Frame timing derived from the SCLK protocol: setup + FB full periods + hold.
    localparam int CSN_LOW    = CD * (2 + 2 * FB);
    localparam int FIRST_RISE = 2 * CD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    // DUT A: default parameters.
    logic        rst_a, en_a;
    logic        miso_a = 1'b0;
    logic        sclk_a, csn_a, rcv_a, busy_a, ovr_a;
    logic [11:0] data_a;

    // DUT B: period shorter than one frame.
    logic        rst_b, en_b;
    logic        miso_b = 1'b0;
    logic        sclk_b, csn_b, rcv_b, busy_b, ovr_b;
    logic [11:0] data_b;

    adc_spi_reader dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .miso(miso_a),
        .sclk(sclk_a), .cs_n(csn_a), .data(data_a),
        .spiReceived(rcv_a), .busy(busy_a), .overrun(ovr_a)
    );

    adc_spi_reader #(.PERIOD(PER_S)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .miso(miso_b),
        .sclk(sclk_b), .cs_n(csn_b), .data(data_b),
        .spiReceived(rcv_b), .busy(busy_b), .overrun(ovr_b)
    );

    // ADC models: latch a 16-bit word on cs_n fall, present MSB, next bit after each SCLK fall.
    logic [15:0] words_a[$], words_b[$];
    logic [11:0] exp_a[$], exp_b[$];
    logic [15:0] word_a, word_b;
    int idx_a = 0, idx_b = 0;

    always @(negedge csn_a) begin
        word_a = (words_a.size() > 0) ? words_a.pop_front() : 16'($urandom);
        exp_a.push_back(word_a[11:0]);
        idx_a  = 15;
        miso_a = word_a[15];
    end
    always @(negedge sclk_a) begin
        if (!csn_a && idx_a > 0) begin
            idx_a--;
            miso_a = word_a[idx_a];
        end
    end

    always @(negedge csn_b) begin
        word_b = (words_b.size() > 0) ? words_b.pop_front() : 16'($urandom);
        exp_b.push_back(word_b[11:0]);
        idx_b  = 15;
        miso_b = word_b[15];
    end
    always @(negedge sclk_b) begin
        if (!csn_b && idx_b > 0) begin
            idx_b--;
            miso_b = word_b[idx_b];
        end
    end

    // Strobe timestamps and data-stability watch on DUT A.
    int   rise_cyc_a[$];
    int   bad_data_a = 0;
    logic rcv_prev_a;
    logic [11:0] data_prev_a;
    always @(negedge clk) begin
        if (rcv_a === 1'b1 && rcv_prev_a !== 1'b1) rise_cyc_a.push_back(cyc);
        if (rst_a === 1'b0 && data_a !== data_prev_a &&
            !(rcv_a === 1'b1 && rcv_prev_a !== 1'b1)) bad_data_a++;
        rcv_prev_a  = rcv_a;
        data_prev_a = data_a;
    end

    // Downstream channel switcher: two-flop synchroniser plus rising-edge detect.
    logic [1:0] sw_sync_a = 2'b00;
    int chan_a = 0;
    always @(posedge clk) begin
        if (sw_sync_a[0] && !sw_sync_a[1]) chan_a++;
        sw_sync_a <= {sw_sync_a[0], rcv_a};
    end

    int frames_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Poll at negedges until the selected signal reaches val; waited = negedges elapsed.
    task automatic wait_for(input string tag, input int sel, input logic val,
                            input int bound, output int waited);
        logic s;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            case (sel)
                0:       s = csn_a;
                1:       s = csn_b;
                default: s = rcv_b;
            endcase
        end while (s !== val && waited < bound);
        chk({tag, "_seen"}, 32'(s === val), 32'd1);
    endtask

    // Entered at the first negedge with cs_n low on DUT A; follows the frame to strobe end.
    task automatic measure_a(input string tag, input int drop_at, input int reset_at);
        int n, low, rises, rcvw, first_rise, done_at;
        bit seen_rcv;
        logic ps;
        logic [11:0] e;
        n = 0; low = 0; rises = 0; rcvw = 0; first_rise = -1; done_at = -1;
        seen_rcv = 0;
        ps = sclk_a;
        while (n < 400) begin
            if (csn_a === 1'b0) low++;
            if (sclk_a === 1'b1 && ps !== 1'b1) begin
                rises++;
                if (first_rise < 0) first_rise = n;
                if (rises == drop_at) en_a = 1'b0;
                if (rises == reset_at) begin
                    @(posedge clk);
                    #1 rst_a = 1'b1;
                    #1;
                    chk("rst_mid_csn",  32'(csn_a), 32'd1);
                    chk("rst_mid_sclk", 32'(sclk_a), 32'd0);
                    chk("rst_mid_rcv",  32'(rcv_a), 32'd0);
                    chk("rst_mid_data", 32'(data_a), 32'd0);
                    chk("rst_mid_busy", 32'(busy_a), 32'd0);
                    exp_a.delete();
                    repeat (3) @(posedge clk);
                    #1 rst_a = 1'b0;
                    return;
                end
            end
            ps = sclk_a;
            if (rcv_a === 1'b1) begin
                rcvw++;
                if (!seen_rcv) begin
                    seen_rcv = 1;
                    done_at  = n;
                end
            end else if (seen_rcv) begin
                break;
            end
            n++;
            @(negedge clk);
        end
        if (seen_rcv) frames_a++;
        chk({tag, "_ended"},      32'(seen_rcv && rcv_a === 1'b0), 32'd1);
        chk({tag, "_sclk_rises"}, 32'(rises), 32'(FB));
        chk({tag, "_csn_low"},    32'(low), 32'(CSN_LOW));
        chk({tag, "_first_rise"}, 32'(first_rise), 32'(FIRST_RISE));
        chk({tag, "_done_at"},    32'(done_at), 32'(CSN_LOW));
        chk({tag, "_rcv_width"},  32'(rcvw), 32'(DW));
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 12'hxxx;
        chk({tag, "_data"},       32'(data_a), 32'(e));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, csn_seen, t_last;
        logic [11:0] e;

        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_csn",  32'(csn_a), 32'd1);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_rcv",  32'(rcv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ovr",  32'(ovr_a), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Known pattern then consecutive frames at the default period.
        words_a = {16'h0ABC, 16'h0FFF, 16'h0000, 16'h0555, 16'($urandom)};
        @(negedge clk);
        en_a = 1'b1;
        wait_for("a_start0", 0, 1'b0, PER + 20, w);
        chk("a_first_start", 32'(w), 32'(PER + 1));
        chk("a_busy_in_frame", 32'(busy_a), 32'd1);
        measure_a("f_abc", 0, 0);
        measure_a_wrap("f_fff");
        measure_a_wrap("f_000");
        measure_a_wrap("f_555");
        chk("a_ovr_nominal", 32'(ovr_a), 32'd0);

        // Enable drops during SHIFT bit 5: frame finishes, no further activity.
        wait_for("a_start_drop", 0, 1'b0, PER + 20, w);
        measure_a("f_drop", 5, 0);
        chk("a_rise_count", 32'(rise_cyc_a.size()), 32'd5);
        if (rise_cyc_a.size() >= 5) begin
            for (int i = 1; i < 5; i++)
                chk("a_rise_spacing", 32'(rise_cyc_a[i] - rise_cyc_a[i-1]), 32'(PER));
        end
        csn_seen = 0;
        repeat (2 * PER) begin
            @(negedge clk);
            if (csn_a !== 1'b1) csn_seen++;
        end
        chk("a_idle_after_drop", 32'(csn_seen), 32'd0);
        chk("a_timer_held", 32'(dut_a.u_timer.count), 32'd0);

        // Reset at SHIFT bit 8, then restart timing from reset release.
        @(negedge clk);
        en_a = 1'b1;
        wait_for("a_start_rst", 0, 1'b0, PER + 20, w);
        measure_a("f_rst", 0, 8);
        @(negedge clk);
        wait_for("a_start_after_rst", 0, 1'b0, PER + 20, w);
        chk("a_restart_delay", 32'(w), 32'(PER + 1));
        measure_a("f_post_rst", 0, 0);
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("a_switcher_advances", 32'(chan_a), 32'(frames_a));
        chk("a_data_stable", 32'(bad_data_a), 32'd0);

        // Short period: every other trigger overruns, frames still deliver data.
        @(negedge clk);
        en_b = 1'b1;
        wait_for("b_start0", 1, 1'b0, PER_S + 20, w);
        chk("b_first_start", 32'(w), 32'(PER_S + 1));
        chk("b_ovr_initial", 32'(ovr_b), 32'd0);
        t_last = cyc;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                wait_for("b_start", 1, 1'b0, 3 * PER_S, w);
                chk("b_start_spacing", 32'(cyc - t_last), 32'(2 * PER_S));
                t_last = cyc;
            end
            wait_for("b_rcv_hi", 2, 1'b1, 2 * CSN_LOW, w);
            chk("b_rcv_latency", 32'(cyc - t_last), 32'(CSN_LOW));
            e = (exp_b.size() > 0) ? exp_b.pop_front() : 12'hxxx;
            chk("b_data", 32'(data_b), 32'(e));
            wait_for("b_rcv_lo", 2, 1'b0, DW + 4, w);
            chk("b_rcv_width", 32'(w), 32'(DW));
            chk("b_ovr_sticky", 32'(ovr_b), 32'd1);
        end
        en_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic measure_a_wrap(input string tag);
        int w;
        wait_for({tag, "_start"}, 0, 1'b0, PER + 20, w);
        measure_a(tag, 0, 0);
    endtask

endmodule
